// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial pattern detector with run-time overlap mode and valid qualification.
// Optional saturating match counter enabled by defining SEQ_DET_COUNT_EN.
module seq_detector_param #(
    parameter int unsigned        PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int unsigned        CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             din_valid,
    input  logic             din,
    input  logic             overlap_en,
    output logic             dout
`ifdef SEQ_DET_COUNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    localparam int unsigned HistW = PAT_LEN - 1;
    localparam int unsigned FillW = $clog2(PAT_LEN);
    localparam logic [FillW-1:0] FillMax = FillW'(PAT_LEN - 1);

    if (PAT_LEN < 2 || PAT_LEN > 32) begin : g_bad_pat_len
        $error("seq_detector_param: PAT_LEN must be in 2..32");
    end
    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("seq_detector_param: CNT_W must be at least 1");
    end

    logic [HistW-1:0]   hist_q, hist_d;
    logic [FillW-1:0]   fill_q, fill_d;
    logic [PAT_LEN-1:0] window;
    logic               hit;

    always_comb begin
        window = {hist_q, din};
        hit    = (fill_q == FillMax) && (window == PATTERN);
        dout   = din_valid && !clr && hit;
        hist_d = hist_q;
        fill_d = fill_q;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (din_valid) begin
            // Non-overlapping mode discards the whole history so no suffix is reused.
            if (dout && !overlap_en) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = window[HistW-1:0];
                if (fill_q != FillMax) begin
                    fill_d = fill_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (dout && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`endif

endmodule
